// File: rtl/if_stage_pkg.sv
// Shared types and constants for the instruction fetch stage and its decode interface.
package if_stage_pkg;

  localparam int unsigned IF_DATA_WIDTH = 32;
  localparam int unsigned IF_INST_WIDTH = 32;
  localparam int unsigned IF_BUF_DEPTH  = 2;

  // addi x0,x0,0 -- used downstream to inject bubbles
  localparam logic [IF_INST_WIDTH-1:0] IF_NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic                     redirect;
    logic [IF_DATA_WIDTH-1:0] target;
  } if_stage_in_frm_ex_t;

  typedef struct packed {
    logic                     valid;
    logic [IF_INST_WIDTH-1:0] inst;
    logic [IF_DATA_WIDTH-1:0] pc;
    logic [IF_DATA_WIDTH-1:0] pc4;
  } if_stage_out_t;

endpackage

// File: rtl/if_fifo.sv
// Small synchronous FIFO with clear and occupancy count; DEPTH must be a power of two.
module if_fifo #(
  parameter  int unsigned WIDTH = 32,
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  input  logic             i_clear,
  output logic [WIDTH-1:0] o_data,
  output logic [CNT_W-1:0] o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign w_pop  = i_pop && (r_count != '0);
  assign w_push = i_push && ((r_count != CNT_W'(DEPTH)) || w_pop);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  // Storage carries no reset; consumers qualify the head with the count.
  always_ff @(posedge clk) begin
    if (w_push && !i_clear) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC generation, credit-limited imem requests,
// response buffering for decode and redirect flushing of in-flight fetches.
module if_stage
  import if_stage_pkg::*;
#(
  parameter int unsigned          DATA_WIDTH = IF_DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] RESET_PC  = '0,
  parameter int unsigned          BUF_DEPTH  = IF_BUF_DEPTH
) (
  input  logic                     clk,
  input  logic                     arst_n,
  output logic                     imem_req_valid,
  input  logic                     imem_req_ready,
  output logic [DATA_WIDTH-1:0]    imem_req_addr,
  input  logic                     imem_rsp_valid,
  input  logic [IF_INST_WIDTH-1:0] imem_rsp_data,
  input  logic                     stall,
  input  if_stage_in_frm_ex_t      if_stage_in_frm_ex,
  output if_stage_out_t            if_stage_out
);

  localparam int unsigned CNT_W = $clog2(BUF_DEPTH) + 1;
  localparam int unsigned OCC_W = CNT_W + 1;
  localparam int unsigned ENT_W = IF_INST_WIDTH + DATA_WIDTH;

  logic [DATA_WIDTH-1:0] r_pc;
  logic                  r_run;
  logic [CNT_W-1:0]      r_drop_cnt;

  logic [CNT_W-1:0]      w_inflight_cnt;
  logic [CNT_W-1:0]      w_buf_cnt;
  logic [DATA_WIDTH-1:0] w_rsp_pc;
  logic [ENT_W-1:0]      w_buf_head;
  logic [DATA_WIDTH-1:0] w_redirect_pc;
  logic [OCC_W-1:0]      w_occupancy;
  logic                  w_redirect;
  logic                  w_buf_valid;
  logic                  w_pop;
  logic                  w_accept;
  logic                  w_buf_push;

  assign w_redirect    = if_stage_in_frm_ex.redirect;
  assign w_redirect_pc = if_stage_in_frm_ex.target & ~DATA_WIDTH'(3);
  assign w_buf_valid   = (w_buf_cnt != '0);
  assign w_pop         = w_buf_valid && !stall && !w_redirect;

  // Every accepted fetch owns a buffer slot until decode consumes it.
  assign w_occupancy    = OCC_W'(w_inflight_cnt) + OCC_W'(w_buf_cnt) - OCC_W'(w_pop);
  assign imem_req_valid = r_run && !w_redirect && (w_occupancy < OCC_W'(BUF_DEPTH));
  assign imem_req_addr  = r_pc;
  assign w_accept       = imem_req_valid && imem_req_ready;
  assign w_buf_push     = imem_rsp_valid && (r_drop_cnt == '0) && !w_redirect;

  if_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(BUF_DEPTH)) u_pc_queue (
    .clk     (clk),
    .arst_n  (arst_n),
    .i_push  (w_accept),
    .i_data  (r_pc),
    .i_pop   (imem_rsp_valid),
    .i_clear (1'b0),
    .o_data  (w_rsp_pc),
    .o_count (w_inflight_cnt)
  );

  if_fifo #(.WIDTH(ENT_W), .DEPTH(BUF_DEPTH)) u_inst_buf (
    .clk     (clk),
    .arst_n  (arst_n),
    .i_push  (w_buf_push),
    .i_data  ({imem_rsp_data, w_rsp_pc}),
    .i_pop   (w_pop),
    .i_clear (w_redirect),
    .o_data  (w_buf_head),
    .o_count (w_buf_cnt)
  );

  // PC, run enable and count of stale responses still owed by memory.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_pc       <= RESET_PC;
      r_run      <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      r_run <= 1'b1;
      if (w_redirect) begin
        r_pc       <= w_redirect_pc;
        r_drop_cnt <= w_inflight_cnt - CNT_W'(imem_rsp_valid);
      end else begin
        if (w_accept) r_pc <= r_pc + DATA_WIDTH'(4);
        if (imem_rsp_valid && (r_drop_cnt != '0)) r_drop_cnt <= r_drop_cnt - CNT_W'(1);
      end
    end
  end

  always_comb begin
    if_stage_out = '0;
    if (w_buf_valid) begin
      if_stage_out.valid = 1'b1;
      if_stage_out.inst  = w_buf_head[ENT_W-1 -: IF_INST_WIDTH];
      if_stage_out.pc    = w_buf_head[DATA_WIDTH-1:0];
      if_stage_out.pc4   = w_buf_head[DATA_WIDTH-1:0] + DATA_WIDTH'(4);
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with an in-order, variable-latency instruction memory model.
module tb_if_stage;
  import if_stage_pkg::*;

  localparam int unsigned    DW     = 32;
  localparam logic [DW-1:0]  RST_PC = 32'h0000_0000;

  logic                clk = 1'b0;
  logic                arst_n;
  logic                imem_req_valid;
  logic                imem_req_ready;
  logic [DW-1:0]       imem_req_addr;
  logic                imem_rsp_valid;
  logic [31:0]         imem_rsp_data;
  logic                stall;
  if_stage_in_frm_ex_t ex;
  if_stage_out_t       out;

  int n_checks = 0;
  int n_pass   = 0;
  int lat      = 1;
  int cyc      = 0;
  int pops     = 0;
  int max_out  = 0;
  logic [DW-1:0] mq_addr [$];
  int            mq_due  [$];
  logic [DW-1:0] exp_pc;
  logic [DW-1:0] exp_req;

  if_stage #(.DATA_WIDTH(DW), .RESET_PC(RST_PC), .BUF_DEPTH(2)) dut (
    .clk                (clk),
    .arst_n             (arst_n),
    .imem_req_valid     (imem_req_valid),
    .imem_req_ready     (imem_req_ready),
    .imem_req_addr      (imem_req_addr),
    .imem_rsp_valid     (imem_rsp_valid),
    .imem_rsp_data      (imem_rsp_data),
    .stall              (stall),
    .if_stage_in_frm_ex (ex),
    .if_stage_out       (out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [DW-1:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out(input int max_cyc, input string tag, input logic [DW-1:0] pc_exp);
    bit seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      @(negedge clk);
      if (out.valid) seen = 1'b1;
    end
    check({tag, "_seen"}, 64'(seen), 64'd1);
    if (seen) check({tag, "_pc"}, 64'(out.pc), 64'(pc_exp));
  endtask

  // Memory: responds in order, cyc+lat after acceptance, one beat per cycle.
  initial begin
    int due;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      imem_rsp_valid = 1'b0;
      if (!arst_n) begin
        mq_addr.delete();
        mq_due.delete();
      end else if (mq_due.size() > 0 && mq_due[0] == cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = inst_of(mq_addr[0]);
        void'(mq_addr.pop_front());
        void'(mq_due.pop_front());
      end
      @(negedge clk);
      if (arst_n && imem_req_valid && imem_req_ready) begin
        due = cyc + lat;
        if (mq_due.size() > 0 && due <= mq_due[$]) due = mq_due[$] + 1;
        mq_addr.push_back(imem_req_addr);
        mq_due.push_back(due);
        if (mq_due.size() > max_out) max_out = mq_due.size();
      end
    end
  end

  // Scoreboard: request addresses and consumed outputs must follow the PC sequence.
  initial begin
    forever begin
      @(negedge clk);
      if (!arst_n) begin
        exp_pc  = RST_PC;
        exp_req = RST_PC;
      end else if (ex.redirect) begin
        check("redirect_no_req", 64'(imem_req_valid), 64'd0);
        exp_pc  = ex.target & ~32'd3;
        exp_req = ex.target & ~32'd3;
      end else begin
        if (imem_req_valid && imem_req_ready) begin
          check("req_addr", 64'(imem_req_addr), 64'(exp_req));
          exp_req = exp_req + 32'd4;
        end
        if (out.valid && !stall) begin
          check("out_pc", 64'(out.pc), 64'(exp_pc));
          check("out_inst", 64'(out.inst), 64'(inst_of(exp_pc)));
          check("out_pc4", 64'(out.pc4), 64'(exp_pc + 32'd4));
          exp_pc = exp_pc + 32'd4;
          pops++;
        end
      end
    end
  end

  initial begin
    int cnt;
    int p0;
    arst_n         = 1'b0;
    imem_req_ready = 1'b1;
    stall          = 1'b0;
    ex             = '0;
    lat            = 1;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_valid", 64'(imem_req_valid), 64'd0);
    check("rst_req_addr", 64'(imem_req_addr), 64'(RST_PC));
    check("rst_out_valid", 64'(out.valid), 64'd0);
    check("rst_out_pc4", 64'(out.pc4), 64'd0);
    #1 arst_n = 1'b1;
    #1 check("pre_run_req", 64'(imem_req_valid), 64'd0);

    // Startup and full-rate streaming with L=1
    @(negedge clk);
    check("first_req_valid", 64'(imem_req_valid), 64'd1);
    check("first_req_addr", 64'(imem_req_addr), 64'h0);
    @(negedge clk);
    check("first_out_early", 64'(out.valid), 64'd0);
    check("second_req_addr", 64'(imem_req_addr), 64'h4);
    @(negedge clk);
    check("first_out_valid", 64'(out.valid), 64'd1);
    check("first_out_pc", 64'(out.pc), 64'h0);
    check("first_out_inst", 64'(out.inst), 64'hC0DE_0000);
    check("first_out_pc4", 64'(out.pc4), 64'h4);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out.valid) cnt++;
    end
    check("throughput_8", 64'(cnt), 64'd8);

    // Stall held three cycles with the buffer full
    tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_valid", 64'(out.valid), 64'd1);
      check("stall_pc", 64'(out.pc), 64'(exp_pc));
      check("stall_no_req", 64'(imem_req_valid), 64'd0);
    end
    tick();
    stall = 1'b0;
    repeat (6) tick();

    // Redirect with L=2 while fetches are outstanding
    lat = 2;
    repeat (6) tick();
    ex.redirect = 1'b1;
    ex.target   = 32'h0000_0100;
    tick();
    ex = '0;
    @(negedge clk);
    check("redir_flush_valid", 64'(out.valid), 64'd0);
    wait_out(20, "redir_l2", 32'h0000_0100);
    repeat (6) tick();

    // Redirect coinciding with a response and a stall, L=1
    lat = 1;
    repeat (8) tick();
    stall       = 1'b1;
    ex.redirect = 1'b1;
    ex.target   = 32'h0000_0203;
    @(negedge clk);
    check("same_cycle_rsp", 64'(imem_rsp_valid), 64'd1);
    tick();
    stall = 1'b0;
    ex    = '0;
    @(negedge clk);
    check("redir_next_req_valid", 64'(imem_req_valid), 64'd1);
    check("redir_next_req_addr", 64'(imem_req_addr), 64'h200);
    check("redir_out_dropped", 64'(out.valid), 64'd0);
    wait_out(10, "redir_l1", 32'h0000_0200);

    // Toggling ready, random latency 1..3, occasional stall
    max_out = 0;
    p0      = pops;
    for (int i = 0; i < 60; i++) begin
      tick();
      imem_req_ready = (i % 2) == 0;
      lat            = $urandom_range(1, 3);
      stall          = ($urandom_range(0, 3) == 0);
    end
    tick();
    imem_req_ready = 1'b1;
    stall          = 1'b0;
    lat            = 1;
    repeat (10) tick();
    check("max_outstanding_le_2", 64'(max_out <= 2), 64'd1);
    check("random_progress", 64'((pops - p0) >= 8), 64'd1);

    // Asynchronous reset in the middle of streaming
    @(negedge clk);
    #1 arst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out.valid), 64'd0);
    check("midrst_out_pc", 64'(out.pc), 64'd0);
    check("midrst_req_valid", 64'(imem_req_valid), 64'd0);
    check("midrst_req_addr", 64'(imem_req_addr), 64'(RST_PC));
    repeat (2) @(negedge clk);
    #1 arst_n = 1'b1;
    @(negedge clk);
    check("restart_req_valid", 64'(imem_req_valid), 64'd1);
    check("restart_req_addr", 64'(imem_req_addr), 64'(RST_PC));
    wait_out(10, "restart", RST_PC);
    repeat (5) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
